// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
// Two-requester round-robin read arbiter and sequencer for a small ROM.
// A granted request drives rom_cs/rom_rd_en/rom_addr for ROM_LAT cycles,
// captures rom_data, and returns it with a one-cycle done pulse to the
// granted requester. Addresses at or above DEPTH never touch the ROM and
// complete with done+err and rdata cleared.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   req0/addr0          requester 0 level request and address
//   done0/err0          requester 0 completion pulse and illegal-address flag
//   req1/addr1          requester 1 level request and address
//   done1/err1          requester 1 completion pulse and illegal-address flag
//   rdata               returned data, held until the next completion
//   rom_cs/rom_rd_en    ROM chip select and read enable (READ state only)
//   rom_addr            ROM address, holds its last value outside READ
//   rom_data            ROM read data
// ---------------------------------------------------------------------------
module rom_read_arbiter #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 24,
    parameter int unsigned ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              done0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              done1,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              rom_cs,
    output logic              rom_rd_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    localparam int unsigned CNT_W    = 3;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic              grant_q;
    logic              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done0_q;
    logic              err0_q;
    logic              done1_q;
    logic              err1_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rom_cs_q;
    logic              rom_rd_en_q;
    logic [ADDR_W-1:0] rom_addr_q;

    logic              gnt_valid_d;
    logic              gnt_id_d;
    logic [ADDR_W-1:0] gnt_addr_d;
    logic              gnt_illegal_d;

    // Round-robin pick: a tie goes to the requester that was not served last.
    always_comb begin
        gnt_valid_d = req0 | req1;
        gnt_id_d    = 1'b0;
        if (req0 && req1) begin
            gnt_id_d = ~last_q;
        end else if (req1) begin
            gnt_id_d = 1'b1;
        end
        gnt_addr_d    = gnt_id_d ? addr1 : addr0;
        // Extra bit keeps the compare correct even if DEPTH == 2**ADDR_W.
        gnt_illegal_d = {1'b0, gnt_addr_d} >= (ADDR_W + 1)'(DEPTH);
    end

    // Sequencer FSM; every output is a register set on entry to its state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            done0_q     <= 1'b0;
            err0_q      <= 1'b0;
            done1_q     <= 1'b0;
            err1_q      <= 1'b0;
            rdata_q     <= '0;
            rom_cs_q    <= 1'b0;
            rom_rd_en_q <= 1'b0;
            rom_addr_q  <= '0;
        end else begin
            done0_q <= 1'b0;
            err0_q  <= 1'b0;
            done1_q <= 1'b0;
            err1_q  <= 1'b0;

            unique case (state_q)
                S_IDLE: begin
                    if (gnt_valid_d) begin
                        grant_q <= gnt_id_d;
                        if (gnt_illegal_d) begin
                            state_q <= S_ERR;
                            rdata_q <= '0;
                            done0_q <= ~gnt_id_d;
                            err0_q  <= ~gnt_id_d;
                            done1_q <= gnt_id_d;
                            err1_q  <= gnt_id_d;
                        end else begin
                            state_q     <= S_READ;
                            cnt_q       <= '0;
                            rom_cs_q    <= 1'b1;
                            rom_rd_en_q <= 1'b1;
                            rom_addr_q  <= gnt_addr_d;
                        end
                    end
                end

                S_READ: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= S_DONE;
                        rdata_q     <= rom_data;
                        rom_cs_q    <= 1'b0;
                        rom_rd_en_q <= 1'b0;
                        done0_q     <= ~grant_q;
                        done1_q     <= grant_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // Completion cycle; requests are not sampled here.
                S_DONE, S_ERR: begin
                    last_q  <= grant_q;
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done0     = done0_q;
    assign err0      = err0_q;
    assign done1     = done1_q;
    assign err1      = err1_q;
    assign rdata     = rdata_q;
    assign rom_cs    = rom_cs_q;
    assign rom_rd_en = rom_rd_en_q;
    assign rom_addr  = rom_addr_q;

endmodule
